// File: rtl/addr_seq_reg.sv
// rtl/addr_seq_reg.sv - sequencing address register with load, step and handshaked burst
// Optional AR_BOUNDS_EN adds lim_lo/lim_hi address window checking and a sticky fault flag.
module addr_seq_reg #(
    parameter int AW   = 16,
    parameter int BLW  = 4,
    parameter int STEP = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic          inc_en,
    input  logic          dec_en,
    input  logic          burst_start,
    input  logic [BLW-1:0] burst_len,
    input  logic          burst_ready,
    output logic [AW-1:0] addr_out,
    output logic          addr_valid,
    output logic          burst_busy,
    output logic          burst_done,
    output logic          wrap
`ifdef AR_BOUNDS_EN
    ,
    input  logic [AW-1:0] lim_lo,
    input  logic [AW-1:0] lim_hi,
    output logic          fault
`endif
);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    localparam logic [AW-1:0] STEP_V = AW'(STEP);

    state_t         state_q, state_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [BLW-1:0] cnt_q, cnt_d;
    logic           done_q, done_d;
    logic           wrap_q, wrap_d;
`ifdef AR_BOUNDS_EN
    logic           fault_q, fault_d;
`endif

    logic [AW-1:0] inc_addr, dec_addr, cand;
    logic          upd, is_beat, cand_wrap, cand_ok;

    assign inc_addr = addr_q + STEP_V;
    assign dec_addr = addr_q - STEP_V;

    // Pick the single candidate address the winning command would produce.
    always_comb begin
        upd       = 1'b0;
        is_beat   = 1'b0;
        cand      = addr_q;
        cand_wrap = 1'b0;
        if (state_q == S_IDLE) begin
            if (ld_en) begin
                upd  = 1'b1;
                cand = ld_addr;
            end else if (inc_en) begin
                upd       = 1'b1;
                cand      = inc_addr;
                cand_wrap = (inc_addr < addr_q);
            end else if (dec_en) begin
                upd       = 1'b1;
                cand      = dec_addr;
                cand_wrap = (dec_addr > addr_q);
            end
        end else begin
            if (ld_en) begin
                upd  = 1'b1;
                cand = ld_addr;
            end else if (burst_ready) begin
                upd       = 1'b1;
                is_beat   = 1'b1;
                cand      = inc_addr;
                cand_wrap = (inc_addr < addr_q);
            end
        end
    end

`ifdef AR_BOUNDS_EN
    assign cand_ok = (cand >= lim_lo) && (cand <= lim_hi);
`else
    assign cand_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
`ifdef AR_BOUNDS_EN
        fault_d = fault_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!ld_en && !inc_en && !dec_en && burst_start) begin
                    state_d = S_BURST;
                    cnt_d   = burst_len;
                end
            end
            S_BURST: begin
                if (ld_en) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (is_beat) begin
                    if (cnt_q == '0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (upd) begin
            if (cand_ok) begin
                addr_d = cand;
                wrap_d = cand_wrap;
            end else begin
`ifdef AR_BOUNDS_EN
                fault_d = 1'b1;
`endif
                // A rejected beat ends the burst without a completion pulse.
                if (is_beat) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
`ifdef AR_BOUNDS_EN
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
`ifdef AR_BOUNDS_EN
            fault_q <= fault_d;
`endif
        end
    end

    assign addr_out   = addr_q;
    assign addr_valid = (state_q == S_BURST);
    assign burst_busy = (state_q == S_BURST);
    assign burst_done = done_q;
    assign wrap       = wrap_q;
`ifdef AR_BOUNDS_EN
    assign fault      = fault_q;
`endif

endmodule

// File: tb/tb_addr_seq_reg.sv
// tb/tb_addr_seq_reg.sv - directed and randomized checks of addr_seq_reg against a reference model
module tb_addr_seq_reg;

    localparam int AW  = 16;
    localparam int BLW = 4;
    localparam int MOD = 1 << AW;
    localparam int STP = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          ld_en = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic          inc_en = 1'b0;
    logic          dec_en = 1'b0;
    logic          burst_start = 1'b0;
    logic [BLW-1:0] burst_len = '0;
    logic          burst_ready = 1'b0;
    logic [AW-1:0] addr_out;
    logic          addr_valid, burst_busy, burst_done, wrap;
`ifdef AR_BOUNDS_EN
    logic [AW-1:0] lim_lo = '0;
    logic [AW-1:0] lim_hi = '1;
    logic          fault;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    int m_addr = 0, m_rem = 0;
    bit m_busy = 0, m_done = 0, m_wrap = 0;

    addr_seq_reg #(.AW(AW), .BLW(BLW), .STEP(STP)) dut (
        .clk(clk), .reset(reset), .ld_en(ld_en), .ld_addr(ld_addr),
        .inc_en(inc_en), .dec_en(dec_en), .burst_start(burst_start),
        .burst_len(burst_len), .burst_ready(burst_ready),
        .addr_out(addr_out), .addr_valid(addr_valid), .burst_busy(burst_busy),
        .burst_done(burst_done), .wrap(wrap)
`ifdef AR_BOUNDS_EN
        , .lim_lo(lim_lo), .lim_hi(lim_hi), .fault(fault)
`endif
    );

    always #5 clk = ~clk;

    // Reference behaviour: remaining-beat count and plain integer arithmetic.
    task automatic model_update();
        int n;
        if (reset) begin
            m_addr = 0; m_busy = 0; m_rem = 0; m_done = 0; m_wrap = 0;
        end else begin
            m_done = 0;
            m_wrap = 0;
            if (!m_busy) begin
                if (ld_en) m_addr = int'(ld_addr);
                else if (inc_en) begin
                    n = m_addr + STP; m_wrap = (n >= MOD); m_addr = n % MOD;
                end else if (dec_en) begin
                    n = m_addr - STP; m_wrap = (n < 0); m_addr = (n + MOD) % MOD;
                end else if (burst_start) begin
                    m_busy = 1; m_rem = int'(burst_len) + 1;
                end
            end else begin
                if (ld_en) begin
                    m_addr = int'(ld_addr); m_busy = 0;
                end else if (burst_ready) begin
                    n = m_addr + STP; m_wrap = (n >= MOD); m_addr = n % MOD;
                    m_rem = m_rem - 1;
                    if (m_rem == 0) begin m_busy = 0; m_done = 1; end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_inputs();
        ld_en = 0; inc_en = 0; dec_en = 0; burst_start = 0;
    endtask

    task automatic test_reset();
        reset = 1; clear_inputs();
        tick(); tick();
        reset = 0;
        n_checks++;
        if (addr_out !== 16'h0000) begin n_fail++; $display("FAIL reset_addr: got %h expected 0000", addr_out); end
        n_checks++;
        if ({addr_valid, burst_busy, burst_done, wrap} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 0000", {addr_valid, burst_busy, burst_done, wrap});
        end
`ifdef AR_BOUNDS_EN
        n_checks++;
        if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b expected 0", fault); end
`endif
    endtask

    task automatic test_load_step();
        ld_en = 1; ld_addr = 16'h1234; tick(); ld_en = 0;
        n_checks++;
        if (addr_out !== 16'h1234) begin n_fail++; $display("FAIL load: got %h expected 1234", addr_out); end
        inc_en = 1; tick(); inc_en = 0;
        n_checks++;
        if (addr_out !== 16'h1235) begin n_fail++; $display("FAIL inc: got %h expected 1235", addr_out); end
        dec_en = 1; tick(); tick(); dec_en = 0;
        n_checks++;
        if (addr_out !== 16'h1233) begin n_fail++; $display("FAIL dec2: got %h expected 1233", addr_out); end
        ld_en = 1; inc_en = 1; ld_addr = 16'h0042; tick(); clear_inputs();
        n_checks++;
        if (addr_out !== 16'h0042) begin n_fail++; $display("FAIL ld_priority: got %h expected 0042", addr_out); end
    endtask

    task automatic test_wrap();
        ld_en = 1; ld_addr = 16'hFFFF; tick(); ld_en = 0;
        n_checks++;
        if (wrap !== 1'b0) begin n_fail++; $display("FAIL load_no_wrap: got %b expected 0", wrap); end
        inc_en = 1; tick(); inc_en = 0;
        n_checks++;
        if ({addr_out, wrap} !== {16'h0000, 1'b1}) begin n_fail++; $display("FAIL inc_wrap: got %h/%b expected 0000/1", addr_out, wrap); end
        tick();
        n_checks++;
        if (wrap !== 1'b0) begin n_fail++; $display("FAIL wrap_pulse: got %b expected 0", wrap); end
        ld_en = 1; ld_addr = 16'h0000; tick(); ld_en = 0;
        dec_en = 1; tick(); dec_en = 0;
        n_checks++;
        if ({addr_out, wrap} !== {16'hFFFF, 1'b1}) begin n_fail++; $display("FAIL dec_wrap: got %h/%b expected ffff/1", addr_out, wrap); end
    endtask

    task automatic test_burst();
        ld_en = 1; ld_addr = 16'h0100; tick(); ld_en = 0;
        burst_start = 1; burst_len = 4'd3; burst_ready = 1; tick(); burst_start = 0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({addr_out, addr_valid, burst_busy, burst_done} !== {16'h0100 + 16'(i), 3'b110}) begin
                n_fail++; $display("FAIL burst_beat%0d: got %h/%b%b%b expected %h/110", i, addr_out, addr_valid, burst_busy, burst_done, 16'h0100 + 16'(i));
            end
            tick();
        end
        n_checks++;
        if ({addr_out, addr_valid, burst_done} !== {16'h0104, 2'b01}) begin
            n_fail++; $display("FAIL burst_end: got %h/%b%b expected 0104/01", addr_out, addr_valid, burst_done);
        end
        tick();
        n_checks++;
        if (burst_done !== 1'b0) begin n_fail++; $display("FAIL done_pulse: got %b expected 0", burst_done); end
    endtask

    task automatic test_burst_stall();
        int cycles = 0;
        ld_en = 1; ld_addr = 16'h0100; tick(); ld_en = 0;
        burst_start = 1; burst_len = 4'd3; burst_ready = 1; tick(); burst_start = 0;
        while (burst_busy === 1'b1 && cycles < 20) begin
            burst_ready = !(cycles >= 1 && cycles <= 3);
            if (cycles >= 1 && cycles <= 3) begin
                n_checks++;
                if (addr_out !== 16'h0101) begin n_fail++; $display("FAIL stall_hold: got %h expected 0101", addr_out); end
            end
            tick();
            cycles++;
        end
        burst_ready = 1;
        n_checks++;
        if (cycles !== 7) begin n_fail++; $display("FAIL stall_cycles: got %0d expected 7", cycles); end
        n_checks++;
        if ({addr_out, burst_done} !== {16'h0104, 1'b1}) begin n_fail++; $display("FAIL stall_end: got %h/%b expected 0104/1", addr_out, burst_done); end
    endtask

    task automatic test_back_to_back();
        ld_en = 1; ld_addr = 16'h0010; tick(); ld_en = 0;
        burst_start = 1; burst_len = 4'd0; burst_ready = 1; tick(); burst_start = 0;
        tick();
        burst_start = 1; burst_len = 4'd1; tick(); burst_start = 0;
        n_checks++;
        if ({addr_out, burst_busy} !== {16'h0011, 1'b1}) begin n_fail++; $display("FAIL back_to_back: got %h/%b expected 0011/1", addr_out, burst_busy); end
        tick(); tick();
        n_checks++;
        if ({addr_out, burst_done} !== {16'h0013, 1'b1}) begin n_fail++; $display("FAIL b2b_end: got %h/%b expected 0013/1", addr_out, burst_done); end
    endtask

    task automatic test_abort();
        ld_en = 1; ld_addr = 16'h0200; tick(); ld_en = 0;
        burst_start = 1; burst_len = 4'd7; burst_ready = 1; tick(); burst_start = 0;
        inc_en = 1; tick(); inc_en = 0;
        n_checks++;
        if (addr_out !== 16'h0201) begin n_fail++; $display("FAIL inc_ignored_in_burst: got %h expected 0201", addr_out); end
        ld_en = 1; ld_addr = 16'h4000; tick(); ld_en = 0;
        n_checks++;
        if ({addr_out, burst_busy, burst_done} !== {16'h4000, 2'b00}) begin
            n_fail++; $display("FAIL abort: got %h/%b%b expected 4000/00", addr_out, burst_busy, burst_done);
        end
        tick();
        n_checks++;
        if (burst_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got %b expected 0", burst_done); end
        burst_start = 1; burst_len = 4'd5; tick(); burst_start = 0;
        tick();
        reset = 1; tick(); reset = 0;
        n_checks++;
        if ({addr_out, addr_valid, burst_busy, burst_done, wrap} !== {16'h0000, 4'b0000}) begin
            n_fail++; $display("FAIL mid_burst_reset: got %h/%b%b%b%b expected 0000/0000", addr_out, addr_valid, burst_busy, burst_done, wrap);
        end
    endtask

    task automatic test_random();
        reset = 1; tick(); reset = 0;
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 199) == 0);
            ld_en       = ($urandom_range(0, 11) == 0);
            inc_en      = ($urandom_range(0, 4) == 0);
            dec_en      = ($urandom_range(0, 4) == 0);
            burst_start = ($urandom_range(0, 2) == 0);
            burst_len   = BLW'($urandom);
            burst_ready = ($urandom_range(0, 3) != 0);
            ld_addr     = ($urandom_range(0, 3) == 0) ? (16'hFFFF - 16'($urandom_range(0, 3))) : 16'($urandom);
            tick();
            n_checks++;
            if (int'(addr_out) !== m_addr || addr_valid !== m_busy || burst_busy !== m_busy || burst_done !== m_done || wrap !== m_wrap) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h v%b b%b d%b w%b expected %h v%b b%b d%b w%b", i,
                         addr_out, addr_valid, burst_busy, burst_done, wrap, m_addr[15:0], m_busy, m_busy, m_done, m_wrap);
            end
        end
        reset = 0; clear_inputs();
    endtask

`ifdef AR_BOUNDS_EN
    task automatic test_bounds();
        lim_lo = 16'h0100; lim_hi = 16'h0102;
        ld_en = 1; ld_addr = 16'h0100; tick(); ld_en = 0;
        burst_start = 1; burst_len = 4'd3; burst_ready = 1; tick(); burst_start = 0;
        tick(); tick(); tick();
        n_checks++;
        if ({addr_out, burst_busy, burst_done, fault} !== {16'h0102, 3'b001}) begin
            n_fail++; $display("FAIL bounds_stop: got %h/%b%b%b expected 0102/001", addr_out, burst_busy, burst_done, fault);
        end
        tick();
        n_checks++;
        if ({burst_done, fault} !== 2'b01) begin n_fail++; $display("FAIL fault_sticky: got %b expected 01", {burst_done, fault}); end
        reset = 1; tick(); reset = 0;
        n_checks++;
        if (fault !== 1'b0) begin n_fail++; $display("FAIL fault_clear: got %b expected 0", fault); end
    endtask
`endif

    initial begin
        test_reset();
        test_load_step();
        test_wrap();
        test_burst();
        test_burst_stall();
        test_back_to_back();
        test_abort();
        test_random();
`ifdef AR_BOUNDS_EN
        test_bounds();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/addr_seq_reg.md
# addr_seq_reg

Parametrised address register with sequencing, the successor to the plain load-enable address register in the datapath. It holds the current memory address and supports direct load, single-step increment/decrement, and a handshaked auto-incrementing burst mode for block transfers. Wrap-around and burst completion are reported as pulses. It sits between the control unit (load/step/burst commands) and the memory interface (consumes `addr_out` with `addr_valid`/`burst_ready`).

## Interface
- `AW`, 16: address width in bits.
- `BLW`, 4: burst-length field width; maximum burst is 2^BLW beats.
- `STEP`, 1: increment/decrement amount per step or beat; must satisfy 1 ≤ STEP < 2^AW.

- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `ld_en` in 1: load `ld_addr` into the address register.
- `ld_addr` in AW: load value.
- `inc_en` in 1: add STEP (IDLE only).
- `dec_en` in 1: subtract STEP (IDLE only).
- `burst_start` in 1: begin a burst at the current address (IDLE only).
- `burst_len` in BLW: beats minus 1, sampled on `burst_start`.
- `burst_ready` in 1: consumer accepts the current beat.
- `addr_out` out AW: current register value, registered.
- `addr_valid` out 1: high while in BURST.
- `burst_busy` out 1: high while in BURST.
- `burst_done` out 1: one-cycle pulse after the last beat is accepted.
- `wrap` out 1: one-cycle pulse when any step crosses the 2^AW boundary.
- `lim_lo`, `lim_hi` in AW: present only with AR_BOUNDS_EN.
- `fault` out 1: present only with AR_BOUNDS_EN.

## Operation
- There are two states: IDLE and BURST. Reset enters IDLE with `addr_out`=0, beat counter=0, and every output at 0.
- In IDLE, commands are prioritised `ld_en` > `inc_en` > `dec_en` > `burst_start`. Lower-priority commands asserted in the same cycle are dropped.
- `burst_start` latches the beat counter as `burst_len` and moves to BURST. The address is unchanged.
- In BURST, a beat is accepted when `addr_valid` and `burst_ready` are both high.
  - Each accepted beat adds STEP to the address and decrements the counter.
  - When the beat is accepted with counter=0, the block returns to IDLE and pulses `burst_done`.
  - After the burst, the address is the start address + (burst_len+1)·STEP, modulo 2^AW.
- While `burst_ready` is low, the address and counter hold.
- `ld_en` in BURST aborts the burst: the address loads, the state returns to IDLE, and `burst_done` is not pulsed.
- `inc_en`, `dec_en` and `burst_start` are ignored in BURST.
- All arithmetic is modulo 2^AW.
  - `wrap` pulses when an increment produces a result below the old value.
  - `wrap` pulses when a decrement produces a result above the old value.
  - A load never pulses `wrap`.

## Timing
- All outputs are registered.
- A command in cycle N is visible on `addr_out` in cycle N+1.
- `addr_valid`/`burst_busy` rise in the cycle after `burst_start`.
- A burst of L beats with `burst_ready` held high occupies exactly L cycles in BURST.
- `burst_done` is high in the first IDLE cycle after the burst, and `addr_valid` is 0 in that cycle.
- A new `burst_start` is accepted in the same cycle as `burst_done`.
- `reset` overrides everything, including a mid-burst state: the next cycle is IDLE with all outputs at 0.

## Configuration
- `AR_BOUNDS_EN` defined: adds `lim_lo`, `lim_hi` and `fault`.
  - A load, step or beat whose resulting address lies outside [lim_lo, lim_hi] is suppressed: the address holds and `fault` sets.
  - A suppressed beat in BURST aborts the burst to IDLE without `burst_done`.
  - `fault` is sticky and clears only on `reset`.
- `AR_BOUNDS_EN` undefined: no limit ports and no `fault`; the full modulo address space is used.

## Test plan
- Reset, then load 0x1234: `addr_out`=0x1234 next cycle. Then `inc_en`: 0x1235. Then `dec_en` twice: 0x1233.
- Load 0xFFFF, then `inc_en`: `addr_out`=0x0000 and `wrap`=1 for one cycle. Load 0x0000, then `dec_en`: 0xFFFF and `wrap`=1.
- Load 0x0100, then `burst_start` with `burst_len`=3 and `burst_ready` high: `addr_out` reads 0x0100, 0x0101, 0x0102, 0x0103 while valid, then 0x0104 with `burst_done`=1.
- Same burst with `burst_ready` low on beat 2 for 3 cycles: `addr_out` holds 0x0101 during the stall. The burst completes after 7 BURST cycles, ending at 0x0104.
- Mid-burst `ld_en` with 0x4000: IDLE next cycle, `addr_out`=0x4000, no `burst_done`. Mid-burst `reset`: all outputs 0.
- With AR_BOUNDS_EN, `lim_lo`=0x0100 and `lim_hi`=0x0102: a burst from 0x0100 with `burst_len`=3 stops at 0x0102 with `fault`=1 and no `burst_done`. `fault` stays set until `reset`.
